if_stage: RTL and testbench



---
 rtl/if_stage.sv | 59 +++++
 tb/tb_if_stage.sv | 125 ++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction-fetch stage; holds the PC and selects the next PC
//            from sequential, branch, jump or register-jump sources.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] beq,
    input  logic [31:0] jr,
    input  logic [3:0]  pc_4_id,
    input  logic [27:0] offset28,
    input  logic        pc_write,
    input  logic [1:0]  pc_src,
    output logic [31:0] pc_out,
    output logic [31:0] pc_4_out
);

    localparam logic [1:0] c_SRC_SEQ    = 2'b00;
    localparam logic [1:0] c_SRC_BRANCH = 2'b01;
    localparam logic [1:0] c_SRC_JUMP   = 2'b10;
    localparam logic [1:0] c_SRC_JR     = 2'b11;

    logic [31:0] r_pc;
    logic [31:0] w_pc_4;
    logic [31:0] w_next_pc;

    // Modulo-2^32 increment; wraps silently at the top of the address space.
    assign w_pc_4 = r_pc + 32'd4;

    always_comb begin
        w_next_pc = w_pc_4;
        case (pc_src)
            c_SRC_SEQ:    w_next_pc = w_pc_4;
            c_SRC_BRANCH: w_next_pc = beq;
            c_SRC_JUMP:   w_next_pc = {pc_4_id, offset28};
            c_SRC_JR:     w_next_pc = jr;
            default:      w_next_pc = w_pc_4;
        endcase
    end

    // Reset outranks the stall, so a pending redirect is dropped on reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (pc_write) begin
            r_pc <= w_next_pc;
        end
    end

    assign pc_out   = r_pc;
    assign pc_4_out = w_pc_4;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Directed-vector scoreboard bench for if_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic [31:0] beq;
    logic [31:0] jr;
    logic [3:0]  pc_4_id;
    logic [27:0] offset28;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [31:0] pc_out;
    logic [31:0] pc_4_out;

    logic [31:0] exp_q[$];
    int          n_vec;
    int          n_miss;
    bit          done;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .beq      (beq),
        .jr       (jr),
        .pc_4_id  (pc_4_id),
        .offset28 (offset28),
        .pc_write (pc_write),
        .pc_src   (pc_src),
        .pc_out   (pc_out),
        .pc_4_out (pc_4_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every edge that has an outstanding expectation is checked.
    always @(posedge clk) begin
        logic [31:0] e;
        logic [31:0] e4;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            e4 = e + 32'd4;
            n_vec++;
            if (pc_out !== e || pc_4_out !== e4) begin
                n_miss++;
                $display("FAIL vec%0d: pc_out=%h pc_4_out=%h, required pc_out=%h pc_4_out=%h",
                         n_vec, pc_out, pc_4_out, e, e4);
            end
        end
    end

    task automatic apply(input logic rst_n, input logic pw, input logic [1:0] src,
                         input logic [31:0] b, input logic [31:0] j,
                         input logic [3:0] nib, input logic [27:0] off,
                         input logic [31:0] exp_pc);
        @(negedge clk);
        reset    = rst_n;
        pc_write = pw;
        pc_src   = src;
        beq      = b;
        jr       = j;
        pc_4_id  = nib;
        offset28 = off;
        exp_q.push_back(exp_pc);
    endtask

    initial begin
        n_vec = 0; n_miss = 0; done = 1'b0;
        reset = 1'b0; pc_write = 1'b1; pc_src = 2'b11;
        beq = '0; jr = 32'h0000_1234; pc_4_id = '0; offset28 = '0;

        // reset wins even with a jr request
        apply(1'b0, 1'b1, 2'b11, 32'h0,   32'h1234, 4'h0, 28'h0, 32'h0000_0000);
        apply(1'b0, 1'b1, 2'b00, 32'h0,   32'h0,    4'h0, 28'h0, 32'h0000_0000);
        // sequential
        apply(1'b1, 1'b1, 2'b00, 32'h0,   32'h0,    4'h0, 28'h0, 32'h0000_0004);
        apply(1'b1, 1'b1, 2'b00, 32'h0,   32'h0,    4'h0, 28'h0, 32'h0000_0008);
        apply(1'b1, 1'b1, 2'b00, 32'h0,   32'h0,    4'h0, 28'h0, 32'h0000_000C);
        // branch (unaligned target) then sequential from it
        apply(1'b1, 1'b1, 2'b01, 32'hF,   32'h0,    4'h0, 28'h0, 32'h0000_000F);
        apply(1'b1, 1'b1, 2'b00, 32'h0,   32'h0,    4'h0, 28'h0, 32'h0000_0013);
        // jump
        apply(1'b1, 1'b1, 2'b10, 32'h0,   32'h0,    4'hA, 28'hF00_0000, 32'hAF00_0000);
        // jr then stall ignoring a branch request
        apply(1'b1, 1'b1, 2'b11, 32'h0,   32'hF0,   4'h0, 28'h0, 32'h0000_00F0);
        apply(1'b1, 1'b0, 2'b01, 32'h500, 32'h0,    4'h0, 28'h0, 32'h0000_00F0);
        apply(1'b1, 1'b0, 2'b01, 32'h500, 32'h0,    4'h0, 28'h0, 32'h0000_00F0);
        apply(1'b1, 1'b0, 2'b01, 32'h500, 32'h0,    4'h0, 28'h0, 32'h0000_00F0);
        // wrap at top of address space
        apply(1'b1, 1'b1, 2'b11, 32'h0,   32'hFFFF_FFFC, 4'h0, 28'h0, 32'hFFFF_FFFC);
        apply(1'b1, 1'b1, 2'b00, 32'h0,   32'h0,    4'h0, 28'h0, 32'h0000_0000);
        // second jump pattern, then reset during a jump request
        apply(1'b1, 1'b1, 2'b10, 32'h0,   32'h0,    4'h5, 28'h123_4560, 32'h5123_4560);
        apply(1'b0, 1'b1, 2'b10, 32'h0,   32'h0,    4'h5, 28'h123_4560, 32'h0000_0000);
        apply(1'b1, 1'b1, 2'b00, 32'h0,   32'h0,    4'h0, 28'h0, 32'h0000_0004);
        // reset while stalled
        apply(1'b0, 1'b0, 2'b11, 32'h0,   32'h77,   4'h0, 28'h0, 32'h0000_0000);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        done = 1'b1;
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: bench did not complete, required completion");
            $fatal(1);
        end
    end

endmodule
`default_nettype wire
